// File: rtl/vga_vblank_scheduler.sv
// vga_vblank_scheduler: frame-tick generator and vblank-window arbiter.
// Detects the first blanking line from the sync generator counters, divides
// frames down to game ticks, and hands the shared object/score write port
// to one of two requesters at a time. Grants happen only while the update
// window is open, so the renderer never sees a partially updated frame.
module vga_vblank_scheduler #(
  parameter int V_ACTIVE       = 480,
  parameter int WIN_CLOSE_LINE = 515,
  parameter int FRAME_DIV      = 1,
  parameter int MAX_BURST      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        in_display_area,
  input  logic        pause,
  input  logic [1:0]  req,
  input  logic [1:0]  done,
  output logic [1:0]  gnt,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic        win_open,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} state_e;

  localparam logic [9:0] VBL_LINE   = 10'(V_ACTIVE);
  localparam logic [9:0] CLOSE_LINE = 10'(WIN_CLOSE_LINE);
  localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_e      state_q;
  logic [7:0]  div_q;
  logic        rr_q;
  logic [1:0]  served_q;
  logic [7:0]  burst_q;
  logic        gidx_q;
  logic [1:0]  gnt_q;
  logic        tick_q;
  logic [15:0] fcnt_q;
  logic        win_q;
  logic        busy_q;
  logic        ovr_q;

  logic       vblank_start;
  logic       win_close;
  logic       abort;
  logic [1:0] pending;
  logic       pick;
  logic       grant_end;

  // Raster position matches: each is true for exactly one pixel per frame.
  assign vblank_start = (counter_y == VBL_LINE)   && (counter_x == 10'd0);
  assign win_close    = (counter_y == CLOSE_LINE) && (counter_x == 10'd0);

  // Any of these forces the window shut while requesters are being served.
  assign abort = win_close || in_display_area;

  // Round-robin choice: the pointed-to requester wins if it is pending.
  assign pending   = req & ~served_q;
  assign pick      = pending[rr_q] ? rr_q : ~rr_q;
  assign grant_end = done[gidx_q] || (burst_q == BURST_LAST);

  assign gnt         = gnt_q;
  assign frame_tick  = tick_q;
  assign frame_count = fcnt_q;
  assign win_open    = win_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= 8'd0;
      rr_q     <= 1'b0;
      served_q <= 2'b00;
      burst_q  <= 8'd0;
      gidx_q   <= 1'b0;
      gnt_q    <= 2'b00;
      tick_q   <= 1'b0;
      fcnt_q   <= 16'd0;
      win_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vblank_start && !pause) begin
            if (div_q != DIV_LAST) begin
              div_q <= div_q + 8'd1;
            end else begin
              div_q    <= 8'd0;
              tick_q   <= 1'b1;
              fcnt_q   <= fcnt_q + 16'd1;
              win_q    <= 1'b1;
              busy_q   <= 1'b1;
              served_q <= 2'b00;
              state_q  <= ARB;
            end
          end
        end
        ARB: begin
          // A vblank while busy means the counters glitched; flag and carry on.
          if (vblank_start) ovr_q <= 1'b1;
          if (abort) begin
            gnt_q   <= 2'b00;
            win_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b1;
            state_q <= IDLE;
          end else if (pending == 2'b00) begin
            // Keep waiting for a late requester until both have been served.
            if (served_q == 2'b11) state_q <= DONE;
          end else begin
            gnt_q   <= pick ? 2'b10 : 2'b01;
            gidx_q  <= pick;
            burst_q <= 8'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (vblank_start) ovr_q <= 1'b1;
          if (abort) begin
            gnt_q   <= 2'b00;
            win_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            burst_q <= burst_q + 8'd1;
            if (grant_end) begin
              served_q[gidx_q] <= 1'b1;
              rr_q             <= ~gidx_q;
              gnt_q            <= 2'b00;
              state_q          <= ARB;
              // done on the final allowed cycle still counts as a clean finish.
              if (!done[gidx_q]) ovr_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (vblank_start || in_display_area) ovr_q <= 1'b1;
          win_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_vblank_scheduler.sv
// Bench for vga_vblank_scheduler: a shrunken raster drives the counters,
// a responder answers grants with done pulses, and a frame-level model
// predicts the output events that a monitor checks from a scoreboard.
module tb_vga_vblank_scheduler;

  localparam int V_ACTIVE       = 20;
  localparam int WIN_CLOSE_LINE = 26;
  localparam int FRAME_DIV      = 3;
  localparam int MAX_BURST      = 32;
  localparam int H_TOTAL        = 16;
  localparam int H_ACTIVE       = 12;
  localparam int V_TOTAL        = 32;
  localparam int WIN_LEN        = (WIN_CLOSE_LINE - V_ACTIVE) * H_TOTAL;
  localparam int NEVER          = 1000000;

  // Event kinds, in the order they are reported within one cycle.
  localparam int K_TICK = 0, K_GRISE = 1, K_GFALL = 2, K_OVR = 3, K_WFALL = 4, K_BFALL = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  counter_x = 10'd0;
  logic [9:0]  counter_y = 10'd0;
  logic        in_display_area = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  done = 2'b00;
  logic [1:0]  gnt;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic        win_open;
  logic        busy;
  logic        overrun;

  vga_vblank_scheduler #(
    .V_ACTIVE(V_ACTIVE), .WIN_CLOSE_LINE(WIN_CLOSE_LINE),
    .FRAME_DIV(FRAME_DIV), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .pause(pause), .req(req), .done(done),
    .gnt(gnt), .frame_tick(frame_tick), .frame_count(frame_count),
    .win_open(win_open), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int kind; int val; } ev_t;
  typedef struct { bit p; int off0; int off1; int k0; int k1; } plan_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model state: unpaused vblanks seen, ticks issued, round-robin owner.
  int  unpaused = 0;
  int  ticks = 0;
  bit  rr_m = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_TICK:  return "frame_tick";
      K_GRISE: return "gnt_rise";
      K_GFALL: return "gnt_fall";
      K_OVR:   return "overrun";
      K_WFALL: return "win_open_fall";
      default: return "busy_fall";
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic push(input int c, input int kind, input int val);
    ev_t e;
    e.c = c; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s cyc=%0d val=%0d required no event", kname(kind), cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.c != cyc || e.kind != kind || e.val != val) begin
        failures++;
        $display("FAIL event got %s cyc=%0d val=%0d required %s cyc=%0d val=%0d",
                 kname(kind), cyc, val, kname(e.kind), e.c, e.val);
      end
    end
  endtask

  // Predict one serviced window: v is the cycle in which row V_ACTIVE col 0
  // is presented. Requester i raises req at rs[i] and answers kk[i] cycles
  // after its grant appears.
  task automatic model_window(input int v, input plan_t pl);
    int t, wc, a, e, i, cand;
    int rs[2];
    int kk[2];
    bit [1:0] served;
    bit p0, p1;
    wc = v + WIN_LEN;
    rs[0] = (pl.off0 == NEVER) ? NEVER : v + pl.off0;
    rs[1] = (pl.off1 == NEVER) ? NEVER : v + pl.off1;
    kk[0] = pl.k0;
    kk[1] = pl.k1;
    served = 2'b00;
    t = v + 1;
    forever begin
      if (t >= wc) begin
        push(wc + 1, K_OVR, 0); push(wc + 1, K_WFALL, 0); push(wc + 1, K_BFALL, 0);
        return;
      end
      if (served == 2'b11) begin
        push(t + 2, K_WFALL, 0); push(t + 2, K_BFALL, 0);
        return;
      end
      a = NEVER;
      for (int j = 0; j < 2; j++) begin
        cand = (rs[j] > t) ? rs[j] : t;
        if (!served[j] && cand < a) a = cand;
      end
      if (a >= wc) begin
        push(wc + 1, K_OVR, 0); push(wc + 1, K_WFALL, 0); push(wc + 1, K_BFALL, 0);
        return;
      end
      p0 = !served[0] && (rs[0] <= a);
      p1 = !served[1] && (rs[1] <= a);
      i = (p0 && p1) ? int'(rr_m) : (p0 ? 0 : 1);
      push(a + 1, K_GRISE, i);
      e = a + 1 + ((kk[i] < MAX_BURST - 1) ? kk[i] : MAX_BURST - 1);
      if (e >= wc) begin
        push(wc + 1, K_GFALL, i); push(wc + 1, K_OVR, 0);
        push(wc + 1, K_WFALL, 0); push(wc + 1, K_BFALL, 0);
        return;
      end
      push(e + 1, K_GFALL, i);
      if (kk[i] > MAX_BURST - 1) push(e + 1, K_OVR, 0);
      served[i] = 1'b1;
      rr_m = (i == 0);
      t = e + 1;
    end
  endtask

  task automatic model_frame(input int v, input plan_t pl);
    if (pl.p) return;
    unpaused++;
    if (unpaused % FRAME_DIV != 0) return;
    ticks++;
    push(v + 1, K_TICK, ticks % 65536);
    model_window(v, pl);
  endtask

  // Monitor: turns output edges into events and pops the scoreboard.
  task automatic monitor();
    logic [1:0] g_prev;
    logic w_prev, b_prev;
    g_prev = 2'b00; w_prev = 1'b0; b_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        g_prev = 2'b00; w_prev = 1'b0; b_prev = 1'b0;
      end else begin
        checks++;
        if (gnt == 2'b11 || (gnt != 2'b00 && !win_open)) begin
          failures++;
          $display("FAIL gnt_invariant cyc=%0d gnt=%b win_open=%b required one-hot inside window",
                   cyc, gnt, win_open);
        end
        if (frame_tick)                   observe(K_TICK, int'(frame_count));
        if (gnt != 2'b00 && g_prev == 0)  observe(K_GRISE, int'(gnt[1]));
        if (gnt == 2'b00 && g_prev != 0)  observe(K_GFALL, int'(g_prev[1]));
        if (overrun)                      observe(K_OVR, 0);
        if (!win_open && w_prev)          observe(K_WFALL, 0);
        if (!busy && b_prev)              observe(K_BFALL, 0);
        g_prev = gnt; w_prev = win_open; b_prev = busy;
      end
    end
  endtask

  // Drive one raster frame; optionally pull reset while requester 1 holds the port.
  task automatic run_frame(input plan_t pl, input bit arm, output bit fired);
    int v, hx, vy, due0, due1;
    logic [1:0] gp;
    fired = 1'b0;
    v = 0; due0 = -1; due1 = -1; gp = 2'b00;
    for (int n = 0; n < V_TOTAL * H_TOTAL; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        v = cyc + V_ACTIVE * H_TOTAL;
        model_frame(v, pl);
        gp = gnt;
      end
      hx = n % H_TOTAL;
      vy = n / H_TOTAL;
      counter_x = 10'(hx);
      counter_y = 10'(vy);
      in_display_area = (vy < V_ACTIVE) && (hx < H_ACTIVE);
      pause = (cyc <= v) ? pl.p : 1'($urandom_range(0, 1));
      req[0] = (pl.off0 != NEVER) && (cyc >= v + pl.off0);
      req[1] = (pl.off1 != NEVER) && (cyc >= v + pl.off1);
      if (gnt[0] && !gp[0]) due0 = cyc + pl.k0;
      if (gnt[1] && !gp[1]) due1 = cyc + pl.k1;
      gp = gnt;
      done = {cyc == due1, cyc == due0};
      if (arm && gnt == 2'b10) begin
        reset = 1'b0;
        #1;
        chk("async_reset_gnt", int'(gnt), 0);
        chk("async_reset_frame_tick", int'(frame_tick), 0);
        chk("async_reset_frame_count", int'(frame_count), 0);
        chk("async_reset_win_open", int'(win_open), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_overrun", int'(overrun), 0);
        exp_q.delete();
        unpaused = 0; ticks = 0; rr_m = 1'b0;
        req = 2'b00; done = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        fired = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_n(input int n, input bit p, input int o0, input int o1, input int k0, input int k1);
    plan_t pl;
    bit f;
    pl.p = p; pl.off0 = o0; pl.off1 = o1; pl.k0 = k0; pl.k1 = k1;
    for (int i = 0; i < n; i++) run_frame(pl, 1'b0, f);
  endtask

  function automatic int rand_off();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 0;
    if (r < 8) return int'($urandom_range(1, 95));
    return NEVER;
  endfunction

  function automatic int rand_k();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return MAX_BURST - 1;
    if (r == 1) return NEVER;
    return int'($urandom_range(0, 40));
  endfunction

  initial begin
    plan_t pl;
    bit    fired;
    int    fc_before;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_win_open", int'(win_open), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b1;

    // No requesters: ticks on every third frame, windows closed by the close line.
    run_n(6, 1'b0, NEVER, NEVER, 0, 0);
    chk("frame_count_after_6_frames", int'(frame_count), 2);
    // Both requesting, quick done: round robin across two windows.
    run_n(6, 1'b0, 0, 0, 4, 4);
    // Requester 0 alone, never done: burst limit and no regrant.
    run_n(3, 1'b0, 0, NEVER, NEVER, 0);
    // Late requester 1 holding through the close line.
    run_n(3, 1'b0, NEVER, 80, 0, NEVER);
    // done on the last allowed cycle versus one cycle too late.
    run_n(3, 1'b0, 0, 0, MAX_BURST - 1, MAX_BURST);
    // Paused frames leave the tick count and divider untouched.
    fc_before = int'(frame_count);
    run_n(4, 1'b1, 0, 0, 4, 4);
    chk("frame_count_held_by_pause", int'(frame_count), fc_before);
    run_n(3, 1'b0, 0, 0, 4, 4);

    for (int f = 0; f < 54; f++) begin
      pl.p    = ($urandom_range(0, 7) == 0);
      pl.off0 = rand_off();
      pl.off1 = rand_off();
      pl.k0   = rand_k();
      pl.k1   = rand_k();
      run_frame(pl, 1'b0, fired);
    end

    // Reset while requester 1 holds the port, then check the restart order.
    pl.p = 1'b0; pl.off0 = 0; pl.off1 = 0; pl.k0 = NEVER; pl.k1 = NEVER;
    fired = 1'b0;
    for (int f = 0; f < 3 && !fired; f++) run_frame(pl, 1'b1, fired);
    chk("reset_mid_grant_reached", int'(fired), 1);
    run_n(3, 1'b0, 0, 0, 2, 2);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
